// File: rtl/led_blink_sequencer.sv
// LED blink sequencer: turns one-cycle event pulses into visible blinks.
// Each accepted event produces ON_MS ms lit followed by OFF_MS ms dark.
// Events arriving while a blink is in progress are held in a saturating
// pending counter, so back-to-back events show up as separate blinks.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | LED dark, nothing pending; start a blink as soon as PENDING > 0
// ON    | LED lit for ON_MS*MS_DIV cycles
// OFF   | LED dark for OFF_MS*MS_DIV cycles, then chain or go idle
module led_blink_sequencer #(
  parameter int CLK_HZ = 50000000,
  parameter int ON_MS  = 100,
  parameter int OFF_MS = 100,
  parameter int QW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          EVT_IN,
  output logic          LED_OUT,
  output logic          BUSY,
  output logic [QW-1:0] PENDING,
  output logic          OVF
);

  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int MAXMS  = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int MW     = (MAXMS > 1) ? $clog2(MAXMS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(MS_DIV - 1);
  localparam logic [MW-1:0] ON_LAST  = MW'(ON_MS - 1);
  localparam logic [MW-1:0] OFF_LAST = MW'(OFF_MS - 1);
  localparam logic [QW-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [MW-1:0] ms_q, ms_d;
  logic [QW-1:0] pend_q, pend_d;
  logic          led_q, led_d;
  logic          ovf_q, ovf_d;

  logic pre_wrap;
  logic on_done;
  logic off_done;
  logic deq;
  logic accept;
  logic drop;

  // Terminal-count decode for the current phase.
  always_comb begin
    pre_wrap = (pre_q == PRE_LAST);
    on_done  = pre_wrap && (ms_q == ON_LAST);
    off_done = pre_wrap && (ms_q == OFF_LAST);
  end

  // Next-state logic; a dequeue happens on every transition into ON.
  always_comb begin
    state_d = state_q;
    deq     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_ON;
          deq     = 1'b1;
        end
      end
      S_ON: begin
        if (on_done) begin
          state_d = S_OFF;
        end
      end
      S_OFF: begin
        if (off_done) begin
          if (pend_q != '0) begin
            state_d = S_ON;
            deq     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Prescaler and ms counter restart on every phase change so each phase
  // length is exact regardless of what came before.
  always_comb begin
    pre_d = pre_q;
    ms_d  = ms_q;
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (pre_wrap) begin
      pre_d = '0;
      ms_d  = ms_q + MW'(1);
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Saturating pending counter; a dequeue frees a slot for a same-cycle event.
  always_comb begin
    accept = EVT_IN && ((pend_q != PEND_MAX) || deq);
    drop   = EVT_IN && (pend_q == PEND_MAX) && !deq;
    pend_d = pend_q;
    if (accept && !deq) begin
      pend_d = pend_q + QW'(1);
    end else if (!accept && deq) begin
      pend_d = pend_q - QW'(1);
    end
    led_d = (state_d == S_ON);
    ovf_d = drop;
  end

  // State, timers, pending count and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      ms_q    <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      ovf_q   <= ovf_d;
    end
  end

  assign LED_OUT = led_q;
  assign OVF     = ovf_q;
  assign PENDING = pend_q;
  assign BUSY    = (state_q != S_IDLE) || (pend_q != '0);

endmodule
